dram_cmd_scheduler: RTL and testbench

In-order DRAM command scheduler that sits between the request queue and the DRAM command bus. It takes the request at the head of the queue, decodes it into bank group, bank, row and column, and tracks which row is open in each of the 16 banks. It issues the required PRE/ACT/RD/WR sequence while honouring tRCD, tRP, tRAS, CL and CWL, then pops the request from the queue. One request is in flight at a time.

---
 rtl/dram_cmd_scheduler.sv | 220 ++++++++++++++++++++++
 tb/tb_dram_cmd_scheduler.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_cmd_scheduler.sv
// dram_cmd_scheduler
//   In-order DRAM command scheduler. Takes the request at the head of the
//   queue, decodes it into bank group / bank / row / column, tracks the open
//   row of each of the 16 banks and issues the PRE/ACT/RD/WR sequence while
//   honouring tRCD, tRP, tRAS, CL and CWL. One request is in flight at a time.
//
//   Build option: define CLOSE_PAGE_EN to precharge the target bank after
//   every access (close-page policy). Undefined: open-page policy.
//
//   Ports:
//     clk          command clock
//     rst_n        synchronous active-low reset
//     req_valid    queue head holds a valid request
//     req_opcode   0 read, 1 write, 2 fetch (read), 3 invalid
//     req_address  byte address of the head request
//     req_pop      one-cycle pulse, queue removes its head
//     cmd_valid    one cycle per issued command
//     cmd          0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE
//     cmd_bg/cmd_bank/cmd_row/cmd_col  command address fields
//     busy         FSM not in IDLE
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | wait for req_valid, latch the decoded request
//   CHECK     | classify hit / miss / conflict / invalid, hold for tRAS
//   DROP      | pop an invalid request without issuing a command
//   PRE       | issue PRE to the target bank
//   PRE_WAIT  | tRP wait (close-page: pop when it expires)
//   ACT       | issue ACT, record the open row
//   ACT_WAIT  | tRCD wait
//   CAS       | issue RD or WR
//   DATA_WAIT | CL/CWL + burst wait (close-page: then precharge)
module dram_cmd_scheduler #(
  parameter int ADDRESS_WIDTH = 33,
  parameter int T_RCD         = 24,
  parameter int T_RP          = 24,
  parameter int T_RAS         = 52,
  parameter int T_CL          = 24,
  parameter int T_CWL         = 20,
  parameter int T_BURST       = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  input  logic [1:0]               req_opcode,
  input  logic [ADDRESS_WIDTH-1:0] req_address,
  output logic                     req_pop,
  output logic                     cmd_valid,
  output logic [2:0]               cmd,
  output logic [1:0]               cmd_bg,
  output logic [1:0]               cmd_bank,
  output logic [14:0]              cmd_row,
  output logic [9:0]               cmd_col,
  output logic                     busy
);

  localparam int T_M0   = (T_RCD > T_RP)  ? T_RCD : T_RP;
  localparam int T_M1   = (T_M0  > T_RAS) ? T_M0  : T_RAS;
  localparam int T_M2   = (T_M1  > T_CL)  ? T_M1  : T_CL;
  localparam int T_M3   = (T_M2  > T_CWL) ? T_M2  : T_CWL;
  localparam int TW     = $clog2(T_M3 + T_BURST + 1);

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4;

  // Down-counter loads: the wait state is entered one cycle after the command,
  // and the exit (or pop) happens on the terminal-count cycle.
`ifdef CLOSE_PAGE_EN
  localparam logic [TW-1:0] LD_RP = TW'(T_RP - 1);
  localparam logic [TW-1:0] LD_RD = TW'(T_CL + T_BURST - 2);
  localparam logic [TW-1:0] LD_WR = TW'(T_CWL + T_BURST - 2);
`else
  localparam logic [TW-1:0] LD_RP = TW'(T_RP - 2);
  localparam logic [TW-1:0] LD_RD = TW'(T_CL + T_BURST - 1);
  localparam logic [TW-1:0] LD_WR = TW'(T_CWL + T_BURST - 1);
`endif
  localparam logic [TW-1:0] LD_RCD  = TW'(T_RCD - 2);
  localparam logic [TW-1:0] RAS_SAT = TW'(T_RAS);
  // ras counter reads k-1 on the k-th cycle after ACT; a PRE decided now
  // lands next cycle, so it is legal once the counter reaches T_RAS-2.
  localparam logic [TW-1:0] RAS_OK  = TW'(T_RAS - 2);

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_DROP, S_PRE, S_PRE_WAIT,
    S_ACT, S_ACT_WAIT, S_CAS, S_DATA_WAIT
  } state_t;

  state_t          state, state_d;
  logic [TW-1:0]   tmr, tmr_d;
  logic [1:0]      op_q;
  logic [1:0]      bg_q, bank_q;
  logic [14:0]     row_q;
  logic [9:0]      col_q;
  logic [15:0]     open_vld;
  logic [14:0]     open_row [16];
  logic [TW-1:0]   ras_cnt  [16];
  logic [3:0]      idx;
  logic            ras_ok;
  logic            addr_unused;

  assign addr_unused = ^req_address[3:0];
  assign idx         = {bg_q, bank_q};
  assign ras_ok      = (ras_cnt[idx] >= RAS_OK);

  assign cmd_bg   = bg_q;
  assign cmd_bank = bank_q;
  assign cmd_row  = row_q;
  assign cmd_col  = col_q;
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      tmr    <= '0;
      op_q   <= '0;
      bg_q   <= '0;
      bank_q <= '0;
      row_q  <= '0;
      col_q  <= '0;
    end else begin
      state <= state_d;
      tmr   <= tmr_d;
      if (state == S_IDLE && req_valid) begin
        op_q   <= req_opcode;
        bg_q   <= req_address[5:4];
        bank_q <= req_address[7:6];
        row_q  <= req_address[32:18];
        col_q  <= req_address[17:8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      open_vld <= '0;
      for (int i = 0; i < 16; i++) begin
        open_row[i] <= '0;
        ras_cnt[i]  <= RAS_SAT;
      end
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (state == S_ACT && idx == 4'(i))
          ras_cnt[i] <= '0;
        else if (ras_cnt[i] < RAS_SAT)
          ras_cnt[i] <= ras_cnt[i] + 1'b1;
      end
      if (state == S_ACT) begin
        open_vld[idx] <= 1'b1;
        open_row[idx] <= row_q;
      end else if (state == S_PRE) begin
        open_vld[idx] <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d   = state;
    tmr_d     = (tmr != '0) ? tmr - 1'b1 : tmr;
    req_pop   = 1'b0;
    cmd_valid = 1'b0;
    cmd       = CMD_NOP;
    case (state)
      S_IDLE:
        if (req_valid) state_d = S_CHECK;
      S_CHECK:
        if (op_q == 2'd3)                                   state_d = S_DROP;
        else if (open_vld[idx] && open_row[idx] == row_q)   state_d = S_CAS;
        else if (!open_vld[idx])                            state_d = S_ACT;
        else if (ras_ok)                                    state_d = S_PRE;
      S_DROP: begin
        req_pop = 1'b1;
        state_d = S_IDLE;
      end
      S_PRE: begin
        cmd_valid = 1'b1;
        cmd       = CMD_PRE;
        tmr_d     = LD_RP;
        state_d   = S_PRE_WAIT;
      end
      S_PRE_WAIT:
        if (tmr == '0) begin
`ifdef CLOSE_PAGE_EN
          req_pop = 1'b1;
          state_d = S_IDLE;
`else
          state_d = S_ACT;
`endif
        end
      S_ACT: begin
        cmd_valid = 1'b1;
        cmd       = CMD_ACT;
        tmr_d     = LD_RCD;
        state_d   = S_ACT_WAIT;
      end
      S_ACT_WAIT:
        if (tmr == '0) state_d = S_CAS;
      S_CAS: begin
        cmd_valid = 1'b1;
        cmd       = (op_q == 2'd1) ? CMD_WR : CMD_RD;
        tmr_d     = (op_q == 2'd1) ? LD_WR : LD_RD;
        state_d   = S_DATA_WAIT;
      end
      S_DATA_WAIT:
        if (tmr == '0) begin
`ifdef CLOSE_PAGE_EN
          // Timer sits at zero while tRAS is still pending.
          if (ras_ok) state_d = S_PRE;
`else
          req_pop = 1'b1;
          state_d = S_IDLE;
`endif
        end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dram_cmd_scheduler.sv
module tb_dram_cmd_scheduler;
  localparam int T_RCD = 24, T_RP = 24, T_RAS = 52, T_CL = 24, T_CWL = 20, T_BURST = 4;
  localparam logic [2:0] C_ACT = 3'd1, C_RD = 3'd2, C_WR = 3'd3, C_PRE = 3'd4, C_POP = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [1:0]  req_opcode = '0;
  logic [32:0] req_address = '0;
  logic        req_pop, cmd_valid, busy;
  logic [2:0]  cmd;
  logic [1:0]  cmd_bg, cmd_bank;
  logic [14:0] cmd_row;
  logic [9:0]  cmd_col;

  dram_cmd_scheduler dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_opcode(req_opcode),
    .req_address(req_address), .req_pop(req_pop), .cmd_valid(cmd_valid), .cmd(cmd),
    .cmd_bg(cmd_bg), .cmd_bank(cmd_bank), .cmd_row(cmd_row), .cmd_col(cmd_col), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          cyc;
    logic [2:0]  cmd;
    logic [1:0]  bg, bank;
    logic [14:0] row;
    logic [9:0]  col;
  } ev_t;

  ev_t obs_q[$];
  ev_t exp_q[$];

  function automatic ev_t mk_ev(input int c, input logic [2:0] k, input logic [1:0] bg,
                                input logic [1:0] bk, input logic [14:0] r, input logic [9:0] cl);
    ev_t e;
    e.cyc = c; e.cmd = k; e.bg = bg; e.bank = bk; e.row = r; e.col = cl;
    return e;
  endfunction

  // Monitor: record every issued command and pop with its cycle number.
  always @(negedge clk) begin
    if (cmd_valid) obs_q.push_back(mk_ev(cyc, cmd, cmd_bg, cmd_bank, cmd_row, cmd_col));
    if (req_pop)   obs_q.push_back(mk_ev(cyc, C_POP, 2'd0, 2'd0, 15'd0, 10'd0));
    if (!cmd_valid) begin
      tests++;
      if (cmd !== 3'd0) begin
        fails++;
        $display("FAIL nop_when_invalid cyc=%0d cmd=%0d want 0", cyc, cmd);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [32:0] rand_addr();
    return {1'($urandom), 32'($urandom)};
  endfunction

  task automatic check_zero(input string name);
    tests++;
    if ({req_pop, cmd_valid, cmd, cmd_bg, cmd_bank, cmd_row, cmd_col, busy} !== 35'd0) begin
      fails++;
      $display("FAIL %s cyc=%0d outputs pop=%0b cv=%0b cmd=%0d bg=%0d bank=%0d row=%0d col=%0d busy=%0b want all 0",
               name, cyc, req_pop, cmd_valid, cmd, cmd_bg, cmd_bank, cmd_row, cmd_col, busy);
    end
  endtask

  // Behavioural model: per-bank open row and time of last ACT.
  bit          m_open [16];
  logic [14:0] m_row  [16];
  int          m_act  [16];

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_open[i] = 0; m_row[i] = '0; m_act[i] = -100000;
    end
  endfunction

  function automatic int model_req(input logic [1:0] op, input logic [32:0] a, input int t);
    logic [1:0]  bg  = a[5:4];
    logic [1:0]  bk  = a[7:6];
    logic [14:0] row = a[32:18];
    logic [9:0]  col = a[17:8];
    int idx = {28'd0, bg, bk};
    int pre = -1, act = -1, cas, pop;
    exp_q.delete();
    if (op == 2'd3) begin
      exp_q.push_back(mk_ev(t + 2, C_POP, 2'd0, 2'd0, 15'd0, 10'd0));
      return t + 2;
    end
    if (m_open[idx] && m_row[idx] == row) begin
      cas = t + 2;
    end else begin
      if (!m_open[idx]) act = t + 2;
      else begin
        pre = (t + 2 > m_act[idx] + T_RAS) ? t + 2 : m_act[idx] + T_RAS;
        act = pre + T_RP;
      end
      cas = act + T_RCD;
      m_open[idx] = 1; m_row[idx] = row; m_act[idx] = act;
    end
    pop = cas + ((op == 2'd1) ? T_CWL : T_CL) + T_BURST;
    if (pre >= 0) exp_q.push_back(mk_ev(pre, C_PRE, bg, bk, row, col));
    if (act >= 0) exp_q.push_back(mk_ev(act, C_ACT, bg, bk, row, col));
    exp_q.push_back(mk_ev(cas, (op == 2'd1) ? C_WR : C_RD, bg, bk, row, col));
    exp_q.push_back(mk_ev(pop, C_POP, 2'd0, 2'd0, 15'd0, 10'd0));
    return pop;
  endfunction

  function automatic bit ev_match(input ev_t o, input ev_t e);
    if (o.cyc != e.cyc || o.cmd !== e.cmd) return 0;
    if (e.cmd == C_POP) return 1;
    if (o.bg !== e.bg || o.bank !== e.bank) return 0;
    if (e.cmd == C_ACT && o.row !== e.row) return 0;
    if ((e.cmd == C_RD || e.cmd == C_WR) && o.col !== e.col) return 0;
    return 1;
  endfunction

  task automatic check_events(input string name);
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL %s event_count got %0d want %0d", name, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests++;
      if (!ev_match(obs_q[i], exp_q[i])) begin
        fails++;
        $display("FAIL %s ev%0d got cyc=%0d cmd=%0d bg=%0d bank=%0d row=%0d col=%0d want cyc=%0d cmd=%0d bg=%0d bank=%0d row=%0d col=%0d",
                 name, i, obs_q[i].cyc, obs_q[i].cmd, obs_q[i].bg, obs_q[i].bank, obs_q[i].row, obs_q[i].col,
                 exp_q[i].cyc, exp_q[i].cmd, exp_q[i].bg, exp_q[i].bank, exp_q[i].row, exp_q[i].col);
      end
    end
    obs_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = 1'b0;
    repeat (3) step();
    check_zero("reset_outputs");
    rst_n = 1'b1;
    obs_q.delete();
    model_reset();
  endtask

  task automatic start_req(input logic [1:0] op, input logic [32:0] a, input int gap, output int t);
    for (int i = 0; i < gap; i++) begin
      req_valid = 1'b0; req_opcode = 2'($urandom); req_address = rand_addr();
      step();
    end
    req_valid = 1'b1; req_opcode = op; req_address = a;
    t = cyc;
  endtask

  // Inputs are scrambled while the request is in flight; the DUT must ignore them.
  task automatic wait_until(input int c);
    while (cyc < c) begin
      step();
      if (cyc < c) begin
        req_valid = 1'($urandom); req_opcode = 2'($urandom); req_address = rand_addr();
      end
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [32:0] addr;
    int          pre, act, cas, pop;
    logic [1:0]  bg, bank;
    logic [14:0] row;
    logic [9:0]  col;
  } vec_t;

  vec_t vt[10];

  initial begin
    int t, pop;
    vt[0] = '{2'd0, 33'h0,          -1,  2, 26, 54, 2'd0, 2'd0, 15'd0, 10'd0}; // cold read
    vt[1] = '{2'd0, 33'h100,        -1, -1,  2, 30, 2'd0, 2'd0, 15'd0, 10'd1}; // hit
    vt[2] = '{2'd0, 33'h40000,       2, 26, 50, 78, 2'd0, 2'd0, 15'd1, 10'd0}; // conflict
    vt[3] = '{2'd1, 33'h0,           2, 26, 50, 74, 2'd0, 2'd0, 15'd0, 10'd0}; // conflict write
    vt[4] = '{2'd3, 33'h1_2345_6789, -1, -1, -1,  2, 2'd0, 2'd0, 15'd0, 10'd0}; // invalid drop
    vt[5] = '{2'd2, 33'h40,         -1,  2, 26, 54, 2'd0, 2'd1, 15'd0, 10'd0}; // fetch bank1
    vt[6] = '{2'd0, 33'h100,        -1, -1,  2, 30, 2'd0, 2'd0, 15'd0, 10'd1}; // bank0 still open
    vt[7] = '{2'd1, 33'h80,         -1,  2, 26, 50, 2'd0, 2'd2, 15'd0, 10'd0}; // cold write bank2
    vt[8] = '{2'd0, 33'h40080,       3, 27, 51, 79, 2'd0, 2'd2, 15'd1, 10'd0}; // tRAS stall
    vt[9] = '{2'd1, 33'h1407FF,     -1,  2, 26, 50, 2'd3, 2'd3, 15'd5, 10'd7}; // bg3 bank3

    do_reset();
    for (int i = 0; i < 10; i++) begin
      start_req(vt[i].op, vt[i].addr, 0, t);
      exp_q.delete();
      if (vt[i].pre >= 0) exp_q.push_back(mk_ev(t + vt[i].pre, C_PRE, vt[i].bg, vt[i].bank, vt[i].row, vt[i].col));
      if (vt[i].act >= 0) exp_q.push_back(mk_ev(t + vt[i].act, C_ACT, vt[i].bg, vt[i].bank, vt[i].row, vt[i].col));
      if (vt[i].cas >= 0) exp_q.push_back(mk_ev(t + vt[i].cas, (vt[i].op == 2'd1) ? C_WR : C_RD,
                                                vt[i].bg, vt[i].bank, vt[i].row, vt[i].col));
      exp_q.push_back(mk_ev(t + vt[i].pop, C_POP, 2'd0, 2'd0, 15'd0, 10'd0));
      wait_until(t + vt[i].pop + 1);
      check_events($sformatf("vec%0d", i));
    end
    req_valid = 1'b0;

    // Randomized requests over a few banks and rows so hits, misses,
    // conflicts and tRAS stalls all occur.
    do_reset();
    for (int n = 0; n < 60; n++) begin
      int r;
      logic [1:0]  op;
      logic [32:0] a;
      r  = $urandom_range(0, 9);
      op = (r < 4) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      a  = rand_addr();
      a[5:4]   = 2'($urandom_range(0, 1));
      a[7:6]   = 2'($urandom_range(0, 1));
      a[32:18] = ($urandom_range(0, 7) == 0) ? 15'h7FFF : 15'($urandom_range(0, 2));
      start_req(op, a, $urandom_range(0, 2), t);
      pop = model_req(op, a, t);
      wait_until(pop + 1);
      check_events($sformatf("rand%0d", n));
    end
    req_valid = 1'b0;

    // Reset in the middle of a cold read: the request is abandoned.
    do_reset();
    start_req(2'd0, 33'h0, 0, t);
    wait_until(t + 10);
    rst_n = 1'b0; req_valid = 1'b0;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      check_zero("rst_mid_outputs");
      step();
    end
    exp_q.delete();
    exp_q.push_back(mk_ev(t + 2, C_ACT, 2'd0, 2'd0, 15'd0, 10'd0));
    check_events("rst_mid_events");

    // After that reset bank 0 must be closed again: the next access is a miss.
    model_reset();
    start_req(2'd0, 33'h100, 0, t);
    pop = model_req(2'd0, 33'h100, t);
    wait_until(pop + 1);
    req_valid = 1'b0;
    check_events("post_rst_miss");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
